// File: rtl/t03_sprite_scheduler.sv
// t03_sprite_scheduler: buffers sprite position updates in shadow registers and commits them to
// the sprite display units only at the start of vertical blanking, and merges the per-sprite
// colors into one registered VGA pixel color (index 0 has the highest draw priority).
// Optional feature macro: T03_COLLISION_EN (sticky per-frame sprite overlap flag).
module t03_sprite_scheduler #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [10:0]                Hcnt,
  input  logic [10:0]                Vcnt,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [1:0]                 upd_id,
  input  logic [10:0]                upd_x,
  input  logic [10:0]                upd_y,
  output logic [11*NUM_SPRITES-1:0]  sprite_x,
  output logic [11*NUM_SPRITES-1:0]  sprite_y,
  input  logic [8*NUM_SPRITES-1:0]   sprite_color,
  input  logic [NUM_SPRITES-1:0]     sprite_disp,
  output logic [7:0]                 pixel_color,
  output logic                       commit_done,
  output logic                       collision
);

  localparam int unsigned CW       = 11;
  localparam int unsigned PW       = 8;
  localparam logic [1:0]  LAST_IDX = 2'(NUM_SPRITES - 1);

  // Reject configurations the 2-bit index and 11-bit counters cannot represent
  if (NUM_SPRITES < 1 || NUM_SPRITES > 4 || H_ACTIVE < 1 || H_ACTIVE > 2048 ||
      V_ACTIVE > 2047) begin : g_cfg_check
    $error("t03_sprite_scheduler: parameter out of range");
  end

  typedef enum logic {ST_RUN, ST_COMMIT} state_t;

  state_t                      state;
  logic [1:0]                  idx;
  logic [CW*NUM_SPRITES-1:0]   shadow_x;
  logic [CW*NUM_SPRITES-1:0]   shadow_y;
  logic [NUM_SPRITES-1:0]      pending;
  logic                        vblank_start_c;
  logic                        xfer_c;
  logic [NUM_SPRITES-1:0]      set_mask_c;
  logic [PW-1:0]               color_c;

  assign vblank_start_c = (Vcnt == CW'(V_ACTIVE)) && (Hcnt == '0);
  assign xfer_c         = upd_valid && upd_ready;

  // One-hot select of the sprite targeted by an accepted update; out-of-range ids select nothing
  always_comb begin
    set_mask_c = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      if (xfer_c && (upd_id == 2'(i))) set_mask_c[i] = 1'b1;
    end
  end

  // Update capture and vblank-synchronous commit sequencer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_RUN;
      idx         <= '0;
      upd_ready   <= 1'b0;
      commit_done <= 1'b0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      pending     <= '0;
      sprite_x    <= '0;
      sprite_y    <= '0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_RUN: begin
          upd_ready <= 1'b1;
          for (int i = 0; i < int'(NUM_SPRITES); i++) begin
            if (set_mask_c[i]) begin
              shadow_x[CW*i +: CW] <= upd_x;
              shadow_y[CW*i +: CW] <= upd_y;
            end
          end
          pending <= pending | set_mask_c;
          // An update accepted on the vblank cycle itself joins this commit
          if (vblank_start_c && ((pending | set_mask_c) != '0)) begin
            state     <= ST_COMMIT;
            idx       <= '0;
            upd_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < int'(NUM_SPRITES); i++) begin
            if ((idx == 2'(i)) && pending[i]) begin
              sprite_x[CW*i +: CW] <= shadow_x[CW*i +: CW];
              sprite_y[CW*i +: CW] <= shadow_y[CW*i +: CW];
              pending[i]           <= 1'b0;
            end
          end
          if (idx == LAST_IDX) begin
            state       <= ST_RUN;
            idx         <= '0;
            commit_done <= 1'b1;
            upd_ready   <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Priority select: lowest-index displayed sprite wins, otherwise background
  always_comb begin
    color_c = BG_COLOR;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (sprite_disp[i]) color_c = sprite_color[PW*i +: PW];
    end
  end

  // Registered pixel output, active in every state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pixel_color <= BG_COLOR;
    else       pixel_color <= color_c;
  end

`ifdef T03_COLLISION_EN
  logic hit;
  logic overlap_c;

  // At least two displayed sprites: clearing the lowest set bit still leaves one set
  assign overlap_c = |(sprite_disp & (sprite_disp - NUM_SPRITES'(1)));

  // Sticky per-frame overlap; published at vblank, an overlap on that cycle belongs to the new frame
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit       <= 1'b0;
      collision <= 1'b0;
    end else if (vblank_start_c) begin
      collision <= hit;
      hit       <= overlap_c;
    end else begin
      hit <= hit | overlap_c;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_t03_sprite_scheduler.sv
// Bench for t03_sprite_scheduler: randomized updates and pixel traffic against a frame-level model.
module tb_t03_sprite_scheduler;

  localparam int unsigned N  = 2;
  localparam logic [7:0]  BG = 8'h00;
`ifdef T03_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nrst;
  logic [10:0]       Hcnt, Vcnt;
  logic              upd_valid;
  logic              upd_ready;
  logic [1:0]        upd_id;
  logic [10:0]       upd_x, upd_y;
  logic [11*N-1:0]   sprite_x, sprite_y;
  logic [8*N-1:0]    sprite_color;
  logic [N-1:0]      sprite_disp;
  logic [7:0]        pixel_color;
  logic              commit_done;
  logic              collision;

  int total  = 0;
  int passed = 0;

  // Model: committed positions, shadow positions, pending set
  logic [10:0] cx [4];
  logic [10:0] cy [4];
  logic [10:0] sx [4];
  logic [10:0] sy [4];
  logic [3:0]  pend;

  t03_sprite_scheduler #(.NUM_SPRITES(N), .H_ACTIVE(800), .V_ACTIVE(600), .BG_COLOR(BG)) dut (
    .clk(clk), .nrst(nrst), .Hcnt(Hcnt), .Vcnt(Vcnt),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id), .upd_x(upd_x), .upd_y(upd_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color), .sprite_disp(sprite_disp),
    .pixel_color(pixel_color), .commit_done(commit_done), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [11*N-1:0] exp_x();
    logic [11*N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[11*i +: 11] = cx[i];
    return r;
  endfunction

  function automatic logic [11*N-1:0] exp_y();
    logic [11*N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[11*i +: 11] = cy[i];
    return r;
  endfunction

  function automatic logic [7:0] ref_pixel(input logic [N-1:0] disp, input logic [8*N-1:0] col);
    for (int i = 0; i < int'(N); i++) begin
      if (disp[i]) return col[8*i +: 8];
    end
    return BG;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      cx[i] = '0; cy[i] = '0; sx[i] = '0; sy[i] = '0;
    end
    pend = '0;
  endtask

  task automatic model_write(input logic [1:0] id, input logic [10:0] x, input logic [10:0] y);
    if (int'(id) < int'(N)) begin
      sx[id] = x; sy[id] = y; pend[id] = 1'b1;
    end
  endtask

  task automatic do_write(input logic [1:0] id, input logic [10:0] x, input logic [10:0] y);
    upd_valid = 1'b1; upd_id = id; upd_x = x; upd_y = y;
    total++;
    if (upd_ready !== 1'b1) $display("FAIL write_ready: got %b expected 1", upd_ready);
    else passed++;
    tick();
    upd_valid = 1'b0;
    model_write(id, x, y);
    total++;
    if (sprite_x !== exp_x() || sprite_y !== exp_y())
      $display("FAIL write_hold: got x=%h y=%h expected x=%h y=%h", sprite_x, sprite_y, exp_x(), exp_y());
    else passed++;
  endtask

  // One vblank_start cycle, optional same-cycle update and sprite_disp only on that cycle
  task automatic run_vblank(input bit with_xfer, input logic [1:0] id, input logic [10:0] x,
                            input logic [10:0] y, input logic [N-1:0] vb_disp);
    bit any;
    Vcnt = 11'd600; Hcnt = 11'd0; sprite_disp = vb_disp;
    if (with_xfer) begin
      upd_valid = 1'b1; upd_id = id; upd_x = x; upd_y = y;
      total++;
      if (upd_ready !== 1'b1) $display("FAIL vb_xfer_ready: got %b expected 1", upd_ready);
      else passed++;
      model_write(id, x, y);
    end
    any = (pend != '0);
    tick();
    upd_valid = 1'b0; Hcnt = 11'd1; sprite_disp = '0;
    if (any) begin
      for (int j = 0; j < int'(N); j++) begin
        total++;
        if (upd_ready !== 1'b0 || commit_done !== 1'b0)
          $display("FAIL commit_busy: cycle %0d got ready=%b done=%b expected ready=0 done=0", j, upd_ready, commit_done);
        else passed++;
        tick();
      end
      for (int i = 0; i < int'(N); i++) begin
        if (pend[i]) begin cx[i] = sx[i]; cy[i] = sy[i]; end
      end
      pend = '0;
      total++;
      if (commit_done !== 1'b1 || upd_ready !== 1'b1)
        $display("FAIL commit_end: got done=%b ready=%b expected done=1 ready=1", commit_done, upd_ready);
      else passed++;
      total++;
      if (sprite_x !== exp_x() || sprite_y !== exp_y())
        $display("FAIL commit_pos: got x=%h y=%h expected x=%h y=%h", sprite_x, sprite_y, exp_x(), exp_y());
      else passed++;
      tick();
      total++;
      if (commit_done !== 1'b0) $display("FAIL done_pulse: got %b expected 0", commit_done);
      else passed++;
    end else begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (commit_done !== 1'b0 || upd_ready !== 1'b1 || sprite_x !== exp_x() || sprite_y !== exp_y())
          $display("FAIL idle_vblank: got done=%b ready=%b x=%h y=%h expected done=0 ready=1 x=%h y=%h",
                   commit_done, upd_ready, sprite_x, sprite_y, exp_x(), exp_y());
        else passed++;
        tick();
      end
    end
    Vcnt = 11'd601;
  endtask

  task automatic test_reset();
    nrst = 1'b0; upd_valid = 1'b1; upd_id = 2'd0; upd_x = 11'd5; upd_y = 11'd6;
    Vcnt = 11'd100; Hcnt = 11'd10; sprite_disp = '0; sprite_color = '0;
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if (upd_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", upd_ready);
    else passed++;
    total++;
    if (sprite_x !== '0 || sprite_y !== '0)
      $display("FAIL reset_pos: got x=%h y=%h expected 0", sprite_x, sprite_y);
    else passed++;
    total++;
    if (commit_done !== 1'b0 || collision !== 1'b0)
      $display("FAIL reset_flags: got done=%b coll=%b expected 0", commit_done, collision);
    else passed++;
    nrst = 1'b1; upd_valid = 1'b0;
    tick();
    total++;
    if (pixel_color !== 8'h00) $display("FAIL reset_pixel: got %h expected 00", pixel_color);
    else passed++;
    total++;
    if (upd_ready !== 1'b1 || sprite_x !== '0)
      $display("FAIL post_reset: got ready=%b x=%h expected ready=1 x=0", upd_ready, sprite_x);
    else passed++;
  endtask

  task automatic test_pixel();
    logic [N-1:0]   d;
    logic [8*N-1:0] c;
    Vcnt = 11'd120; Hcnt = 11'd40;
    sprite_color = {8'hE0, 8'h57}; sprite_disp = 2'b11;
    tick();
    total++;
    if (pixel_color !== 8'h57) $display("FAIL pixel_prio: got %h expected 57", pixel_color);
    else passed++;
    sprite_disp = 2'b00;
    tick();
    total++;
    if (pixel_color !== 8'h00) $display("FAIL pixel_bg: got %h expected 00", pixel_color);
    else passed++;
    for (int k = 0; k < 30; k++) begin
      d = N'($urandom_range(0, (1 << N) - 1));
      c = (8*N)'($urandom);
      sprite_disp = d; sprite_color = c;
      tick();
      total++;
      if (pixel_color !== ref_pixel(d, c))
        $display("FAIL pixel_rand: disp=%b got %h expected %h", d, pixel_color, ref_pixel(d, c));
      else passed++;
    end
    sprite_disp = '0;
    tick();
  endtask

  task automatic test_update();
    Vcnt = 11'd100; Hcnt = 11'd300;
    do_write(2'd0, 11'd100, 11'd50);
    for (int j = 0; j < 5; j++) begin
      Hcnt = 11'(300 + j);
      tick();
      total++;
      if (sprite_x[10:0] !== 11'd0) $display("FAIL pre_vblank_hold: got %0d expected 0", sprite_x[10:0]);
      else passed++;
    end
    Vcnt = 11'd599; Hcnt = 11'd0; tick();
    Vcnt = 11'd600; Hcnt = 11'd5; tick();
    total++;
    if (sprite_x[10:0] !== 11'd0 || upd_ready !== 1'b1)
      $display("FAIL near_vblank: got x0=%0d ready=%b expected 0 1", sprite_x[10:0], upd_ready);
    else passed++;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (sprite_x[10:0] !== 11'd100 || sprite_y[10:0] !== 11'd50)
      $display("FAIL commit_100_50: got x=%0d y=%0d expected 100 50", sprite_x[10:0], sprite_y[10:0]);
    else passed++;
  endtask

  task automatic test_last_wins();
    Vcnt = 11'd50; Hcnt = 11'd20;
    do_write(2'd1, 11'd10, 11'd7);
    do_write(2'd1, 11'd20, 11'd8);
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (sprite_x[21:11] !== 11'd20) $display("FAIL last_wins: got %0d expected 20", sprite_x[21:11]);
    else passed++;
  endtask

  task automatic test_ignored_id();
    Vcnt = 11'd70; Hcnt = 11'd9;
    do_write(2'd2, 11'($urandom), 11'($urandom));
    do_write(2'd3, 11'($urandom), 11'($urandom));
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
  endtask

  task automatic test_same_cycle();
    run_vblank(1'b1, 2'd0, 11'($urandom_range(1, 2047)), 11'($urandom_range(1, 2047)), '0);
  endtask

  task automatic test_random();
    int nw;
    for (int it = 0; it < 12; it++) begin
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) begin
        Vcnt = 11'($urandom_range(0, 599)); Hcnt = 11'($urandom_range(0, 1055));
        do_write(2'($urandom), 11'($urandom), 11'($urandom));
      end
      run_vblank(1'($urandom), 2'($urandom), 11'($urandom), 11'($urandom), '0);
    end
  endtask

  task automatic test_collision();
    sprite_disp = '0; Vcnt = 11'd100; Hcnt = 11'd1;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (collision !== 1'b0) $display("FAIL coll_idle: got %b expected 0", collision);
    else passed++;
    Vcnt = 11'd200; Hcnt = 11'd37; sprite_disp = 2'b11;
    tick();
    sprite_disp = '0;
    tick();
    total++;
    if (collision !== 1'b0) $display("FAIL coll_frameN: got %b expected 0", collision);
    else passed++;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (collision !== COLL_EN) $display("FAIL coll_frameN1: got %b expected %b", collision, COLL_EN);
    else passed++;
    Vcnt = 11'd400; repeat (4) tick();
    total++;
    if (collision !== COLL_EN) $display("FAIL coll_hold: got %b expected %b", collision, COLL_EN);
    else passed++;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (collision !== 1'b0) $display("FAIL coll_frameN2: got %b expected 0", collision);
    else passed++;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, 2'b11);
    total++;
    if (collision !== 1'b0) $display("FAIL coll_simul_old: got %b expected 0", collision);
    else passed++;
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
    total++;
    if (collision !== COLL_EN) $display("FAIL coll_simul_new: got %b expected %b", collision, COLL_EN);
    else passed++;
  endtask

  task automatic test_reset_mid_commit();
    logic [10:0] a;
    a = 11'($urandom_range(1, 2047));
    Vcnt = 11'd300; Hcnt = 11'd3;
    do_write(2'd0, a, 11'($urandom_range(1, 2047)));
    do_write(2'd1, 11'($urandom_range(1, 2047)), 11'($urandom_range(1, 2047)));
    Vcnt = 11'd600; Hcnt = 11'd0; tick();
    Hcnt = 11'd1; tick();
    total++;
    if (sprite_x[10:0] !== a) $display("FAIL mid_partial: got %0d expected %0d", sprite_x[10:0], a);
    else passed++;
    nrst = 1'b0;
    #1;
    total++;
    if (sprite_x !== '0 || sprite_y !== '0 || upd_ready !== 1'b0 || commit_done !== 1'b0 ||
        pixel_color !== BG || collision !== 1'b0)
      $display("FAIL mid_reset: got x=%h y=%h ready=%b done=%b pix=%h coll=%b expected all 0",
               sprite_x, sprite_y, upd_ready, commit_done, pixel_color, collision);
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
    model_clear();
    Vcnt = 11'd10;
    tick();
    run_vblank(1'b0, 2'd0, 11'd0, 11'd0, '0);
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_update();
    test_last_wins();
    test_ignored_id();
    test_same_cycle();
    test_random();
    test_collision();
    test_reset_mid_commit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
